core_hazard_unit: RTL
=====================

Name: core_hazard_unit

Overview:
Parametrised hazard, forwarding and stall controller for the in-order RISC-V pipeline. It sits between the decode stage and the post-decode stages (execute, memory, writeback, extendable via NUM_STAGES). It keeps a shift-register scoreboard of in-flight register writes and uses it to pick operand forwarding sources and to insert load-use bubbles. It generalises the fixed single-path writeback-to-execute forwarding to any depth, any load-data-ready stage, and cache-freeze handling, and adds a load-use stall counter.

Parameters:
XLEN, 32, datapath width
REG_W, 5, register-select width
NUM_STAGES, 3, tracked post-decode stages; index 0 = execute, NUM_STAGES-1 = writeback; legal range >= 2
LOAD_READY, 2, first stage index whose stage_result carries load data; legal range 1..NUM_STAGES-1
CNT_W, 16, load-use counter width

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
icache_stall  in  1  instruction-cache miss; freezes pipeline
dcache_stall  in  1  data-cache miss; freezes pipeline
d_valid  in  1  decode holds a real instruction
d_flush  in  1  squash the decode instruction (branch taken)
d_read_sel1  in  REG_W  rs1
d_read_sel2  in  REG_W  rs2
d_uses1  in  1  rs1 is read
d_uses2  in  1  rs2 is read
d_write_sel  in  REG_W  rd
d_is_wb  in  1  instruction writes rd
d_is_load  in  1  instruction is a load
rf_data1  in  XLEN  regfile read of rs1
rf_data2  in  XLEN  regfile read of rs2
stage_result  in  NUM_STAGES*XLEN  result of stage i at bits [i*XLEN +: XLEN]
op1  out  XLEN  resolved rs1 value
op2  out  XLEN  resolved rs2 value
fwd_sel1  out  $clog2(NUM_STAGES+1)  0 = regfile, i+1 = stage i
fwd_sel2  out  $clog2(NUM_STAGES+1)  same, for rs2
stall  out  1  load-use stall: hold fetch/decode and insert a bubble
advance  out  1  pipeline moves this cycle
loaduse_cnt  out  CNT_W  load-use stall cycles counted

Behaviour:
- Scoreboard: NUM_STAGES entries, each holding {valid, wb, sel, is_load}.
- advance = !icache_stall && !dcache_stall. This is combinational.
- Operand k lookup (combinational):
  - If d_usesk = 0 or selk = 0, fwd_selk = 0 and opk = rf_datak. x0 never forwards and never stalls.
  - Otherwise find the smallest i with entry valid, wb and sel == selk. The youngest match wins.
  - No match: fwd_selk = 0, opk = rf_datak.
  - Match with is_load and i < LOAD_READY: this is a load-use hazard.
  - Any other match: fwd_selk = i+1, opk = stage_result[i].
  - The writeback entry (i = NUM_STAGES-1) also forwards, which covers a same-cycle regfile write and read.
- stall = d_valid && !d_flush && (hazard on op1 || hazard on op2). This is combinational. op/fwd_sel outputs are don't-care while stall = 1.
- Scoreboard update on the clock edge:
  - reset: all valid = 0, loaduse_cnt = 0. Reset has priority over a freeze.
  - else if !advance: all entries hold and the counter holds. stall may still be asserted but is not counted.
  - else: entry[i] <= entry[i-1] for i >= 1.
    - entry[0] <= {1, d_is_wb, d_write_sel, d_is_load} when d_valid && !d_flush && !stall.
    - Otherwise entry[0] becomes a bubble (valid = 0).
  - If advance && stall, loaduse_cnt increments and wraps modulo 2^CNT_W.
- Latency: a load decoded in cycle t sits at index 0 in t+1. A dependent instruction stalls for LOAD_READY advancing cycles, then forwards from stage LOAD_READY.
- Simultaneous d_flush and hazard: the flush wins, stall = 0 and a bubble is inserted.
- Output values after reset: stall = 0, fwd_sel = 0, op = rf_data (scoreboard empty), loaduse_cnt = 0. advance follows the cache stalls.

Test Plan:
- ALU chain: addi x5 ← 7, then add x6 = x5+x5 next cycle -> fwd_sel1 = fwd_sel2 = 1, op1 = op2 = stage_result[0] = 7, stall = 0.
- Load-use: lw x7, then add using x7 next cycle (defaults) -> stall = 1 for 2 advancing cycles, bubbles inserted, then fwd_sel1 = 3 and loaduse_cnt = 2.
- Freeze: assert dcache_stall for 4 cycles during the load-use stall -> scoreboard and counter hold, advance = 0. On release the remaining stall resumes and the final loaduse_cnt = 2.
- Youngest wins: x9 written at index 0 and at index 2 -> fwd_sel = 1. Reading x0 while x0 is "written" -> fwd_sel = 0, op = rf_data.
- Flush with hazard: d_flush = 1 while a load-use is detected -> stall = 0, and entry[0] is invalid next cycle.
- Reset mid-stall, and counter wrap with CNT_W = 2 after 5 stall cycles -> loaduse_cnt = 1. Reset clears all entries and loaduse_cnt = 0 on the next edge.

Source files
------------

// File: rtl/core_hazard_unit.sv
// Hazard, forwarding and load-use stall controller for the in-order pipeline.
// A shift-register scoreboard of in-flight writes selects operand sources and inserts bubbles.
module core_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int REG_W      = 5,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    localparam int FSEL_W    = $clog2(NUM_STAGES + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       icache_stall,
    input  logic                       dcache_stall,
    input  logic                       d_valid,
    input  logic                       d_flush,
    input  logic [REG_W-1:0]           d_read_sel1,
    input  logic [REG_W-1:0]           d_read_sel2,
    input  logic                       d_uses1,
    input  logic                       d_uses2,
    input  logic [REG_W-1:0]           d_write_sel,
    input  logic                       d_is_wb,
    input  logic                       d_is_load,
    input  logic [XLEN-1:0]            rf_data1,
    input  logic [XLEN-1:0]            rf_data2,
    input  logic [NUM_STAGES*XLEN-1:0] stage_result,
    output logic [XLEN-1:0]            op1,
    output logic [XLEN-1:0]            op2,
    output logic [FSEL_W-1:0]          fwd_sel1,
    output logic [FSEL_W-1:0]          fwd_sel2,
    output logic                       stall,
    output logic                       advance,
    output logic [CNT_W-1:0]           loaduse_cnt
);

    logic [NUM_STAGES-1:0] sb_valid_r;
    logic [NUM_STAGES-1:0] sb_wb_r;
    logic [NUM_STAGES-1:0] sb_load_r;
    logic [REG_W-1:0]      sb_sel_r [NUM_STAGES];
    logic [CNT_W-1:0]      loaduse_cnt_r;

    logic                  advance_s;
    logic                  stall_s;
    logic [REG_W-1:0]      rsel_s [2];
    logic [1:0]            ruse_s;
    logic [XLEN-1:0]       rf_s [2];
    logic [FSEL_W-1:0]     fsel_s [2];
    logic [XLEN-1:0]       opv_s [2];
    logic [1:0]            haz_s;

    assign rsel_s[0] = d_read_sel1;
    assign rsel_s[1] = d_read_sel2;
    assign ruse_s    = {d_uses2, d_uses1};
    assign rf_s[0]   = rf_data1;
    assign rf_s[1]   = rf_data2;

    // Per-operand youngest-match search; scanning oldest to youngest lets the youngest hit win.
    always_comb begin
        logic              hit_s;
        logic              hit_early_load_s;
        logic [FSEL_W-1:0] hit_fsel_s;
        logic [XLEN-1:0]   hit_res_s;
        for (int k = 0; k < 2; k++) begin
            fsel_s[k]        = '0;
            opv_s[k]         = rf_s[k];
            haz_s[k]         = 1'b0;
            hit_s            = 1'b0;
            hit_early_load_s = 1'b0;
            hit_fsel_s       = '0;
            hit_res_s        = '0;
            for (int i = NUM_STAGES - 1; i >= 0; i--) begin
                if (sb_valid_r[i] && sb_wb_r[i] && (sb_sel_r[i] == rsel_s[k])) begin
                    hit_s            = 1'b1;
                    hit_early_load_s = sb_load_r[i] && (i < LOAD_READY);
                    hit_fsel_s       = FSEL_W'(i + 1);
                    hit_res_s        = stage_result[i*XLEN +: XLEN];
                end else begin
                    hit_s            = hit_s;
                end
            end
            // x0 is hard-wired, so it neither forwards nor creates a hazard.
            if (ruse_s[k] && (rsel_s[k] != '0) && hit_s) begin
                if (hit_early_load_s) begin
                    haz_s[k] = 1'b1;
                end else begin
                    fsel_s[k] = hit_fsel_s;
                    opv_s[k]  = hit_res_s;
                end
            end else begin
                haz_s[k] = 1'b0;
            end
        end
    end

    assign advance_s   = !icache_stall && !dcache_stall;
    assign stall_s     = d_valid && !d_flush && (|haz_s);

    assign advance     = advance_s;
    assign stall       = stall_s;
    assign op1         = opv_s[0];
    assign op2         = opv_s[1];
    assign fwd_sel1    = fsel_s[0];
    assign fwd_sel2    = fsel_s[1];
    assign loaduse_cnt = loaduse_cnt_r;

    // Scoreboard shift and load-use counter; a cache freeze holds everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            sb_valid_r    <= '0;
            sb_wb_r       <= '0;
            sb_load_r     <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                sb_sel_r[i] <= '0;
            end
            loaduse_cnt_r <= '0;
        end else if (advance_s) begin
            for (int i = 1; i < NUM_STAGES; i++) begin
                sb_valid_r[i] <= sb_valid_r[i-1];
                sb_wb_r[i]    <= sb_wb_r[i-1];
                sb_load_r[i]  <= sb_load_r[i-1];
                sb_sel_r[i]   <= sb_sel_r[i-1];
            end
            sb_valid_r[0] <= d_valid && !d_flush && !stall_s;
            sb_wb_r[0]    <= d_is_wb;
            sb_load_r[0]  <= d_is_load;
            sb_sel_r[0]   <= d_write_sel;
            if (stall_s) begin
                loaduse_cnt_r <= loaduse_cnt_r + CNT_W'(1);
            end else begin
                loaduse_cnt_r <= loaduse_cnt_r;
            end
        end else begin
            loaduse_cnt_r <= loaduse_cnt_r;
        end
    end

endmodule
